// File: rtl/decode_issue_stage_if.sv
// Bus bundle for decode_issue_stage: fetch handshake, ALU issue bundle, write-back and status.
// The master side is the surrounding pipeline; the slave side is the decode/issue stage.
interface decode_issue_stage_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;

    logic        ex_valid;
    logic        ex_ready;
    logic [31:0] ex_in1;
    logic [31:0] ex_in2;
    logic [3:0]  ex_opcode;
    logic [2:0]  ex_sr_cont;
    logic [4:0]  ex_sr_bit;
    logic        ex_s;
    logic [15:0] ex_imm;
    logic [3:0]  ex_rd;

    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_flags_en;
    logic [3:0]  wb_flags;

    logic [3:0]  flags;
    logic [15:0] squash_cnt;

    modport master (
        output in_valid, instr, ex_ready,
        output wb_en, wb_addr, wb_data, wb_flags_en, wb_flags,
        input  in_ready, ex_valid, ex_in1, ex_in2, ex_opcode, ex_sr_cont,
        input  ex_sr_bit, ex_s, ex_imm, ex_rd, flags, squash_cnt
    );

    modport slave (
        input  in_valid, instr, ex_ready,
        input  wb_en, wb_addr, wb_data, wb_flags_en, wb_flags,
        output in_ready, ex_valid, ex_in1, ex_in2, ex_opcode, ex_sr_cont,
        output ex_sr_bit, ex_s, ex_imm, ex_rd, flags, squash_cnt
    );
endinterface

// File: rtl/decode_issue_stage.sv
// Decode/issue stage: register file with write-back bypass, RAW scoreboard, flags-pending
// tracking, condition evaluation and a single-entry output register towards the ALU.
module decode_issue_stage #(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic                  clk,
    input  logic                  rst,
    decode_issue_stage_if.slave   bus
);
    logic [31:0] r_rf [16];
    logic [15:0] r_sb;
    logic [1:0]  r_fcnt;
    logic [3:0]  r_flags;
    logic [15:0] r_squash;

    logic        r_ex_valid;
    logic [31:0] r_ex_in1;
    logic [31:0] r_ex_in2;
    logic [3:0]  r_ex_opcode;
    logic [2:0]  r_ex_sr_cont;
    logic [4:0]  r_ex_sr_bit;
    logic        r_ex_s;
    logic [15:0] r_ex_imm;
    logic [3:0]  r_ex_rd;

    logic [3:0]  w_cond, w_op, w_rd, w_rn, w_rm;
    logic        w_s;
    logic [2:0]  w_sr_cont;
    logic [4:0]  w_sr_bit;
    logic [15:0] w_imm;
    logic        w_hit_rn, w_hit_rm;
    logic [31:0] w_op1, w_op2;
    logic        w_use_rn, w_use_rm, w_raw;
    logic        w_impl, w_sets_flags, w_stall;
    logic        w_in_ready, w_accept, w_pass, w_issue, w_squash, w_fl_inc;
    logic [15:0] w_sb_next;
    logic [1:0]  w_fcnt_next;

    function automatic logic f_cond_pass(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cy, v;
        {n, z, cy, v} = f;
        case (c)
            4'b0000: return z;
            4'b0001: return !z;
            4'b0010: return cy;
            4'b0011: return !cy;
            4'b0100: return n;
            4'b0101: return !n;
            4'b0110: return v;
            4'b0111: return !v;
            4'b1000: return cy && !z;
            4'b1001: return !cy || z;
            4'b1010: return n == v;
            4'b1011: return n != v;
            4'b1100: return !z && (n == v);
            4'b1101: return z || (n != v);
            4'b1110: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    assign w_cond    = bus.instr[31:28];
    assign w_op      = bus.instr[27:24];
    assign w_s       = bus.instr[23];
    assign w_rd      = bus.instr[22:19];
    assign w_rn      = bus.instr[18:15];
    assign w_rm      = bus.instr[14:11];
    assign w_sr_cont = bus.instr[10:8];
    assign w_sr_bit  = bus.instr[7:3];
    assign w_imm     = bus.instr[15:0];

    // Same-cycle write-back both bypasses the operand and releases the RAW hazard.
    assign w_hit_rn = bus.wb_en && (bus.wb_addr == w_rn);
    assign w_hit_rm = bus.wb_en && (bus.wb_addr == w_rm);
    assign w_op1    = w_hit_rn ? bus.wb_data : r_rf[w_rn];
    assign w_op2    = w_hit_rm ? bus.wb_data : r_rf[w_rm];

    assign w_use_rn = (w_op != 4'b0110);
    assign w_use_rm = w_use_rn && (w_op != 4'b0111);
    assign w_raw    = (w_use_rn && r_sb[w_rn] && !w_hit_rn) ||
                      (w_use_rm && r_sb[w_rm] && !w_hit_rm);

    assign w_impl       = (w_op <= 4'b1000);
    assign w_sets_flags = w_impl && (w_s || (w_op == 4'b1000));
    assign w_stall      = w_raw ||
                          ((w_cond != 4'b1110) && (r_fcnt != 2'd0)) ||
                          (w_sets_flags && (r_fcnt == 2'd3));

    assign w_in_ready = !rst && !w_stall && (!r_ex_valid || bus.ex_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_pass     = f_cond_pass(w_cond, r_flags);
    assign w_issue    = w_accept && w_impl && w_pass;
    assign w_squash   = w_accept && w_impl && !w_pass;
    assign w_fl_inc   = w_issue && w_sets_flags;

    // Clear before set so an issue targeting a register being written back stays pending.
    always_comb begin
        w_sb_next = r_sb;
        if (bus.wb_en) w_sb_next[bus.wb_addr] = 1'b0;
        if (w_issue && (w_op <= 4'b0111)) w_sb_next[w_rd] = 1'b1;
    end

    always_comb begin
        w_fcnt_next = r_fcnt;
        if (w_fl_inc && !bus.wb_flags_en)
            w_fcnt_next = r_fcnt + 2'd1;
        else if (!w_fl_inc && bus.wb_flags_en && (r_fcnt != 2'd0))
            w_fcnt_next = r_fcnt - 2'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < 16; i++) r_rf[i] <= '0;
        end else if (bus.wb_en) begin
            r_rf[bus.wb_addr] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sb     <= '0;
            r_fcnt   <= '0;
            r_flags  <= FLAGS_RST;
            r_squash <= '0;
        end else begin
            r_sb   <= w_sb_next;
            r_fcnt <= w_fcnt_next;
            if (bus.wb_flags_en) r_flags <= bus.wb_flags;
            if (w_squash) r_squash <= r_squash + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ex_valid   <= 1'b0;
            r_ex_in1     <= '0;
            r_ex_in2     <= '0;
            r_ex_opcode  <= '0;
            r_ex_sr_cont <= '0;
            r_ex_sr_bit  <= '0;
            r_ex_s       <= 1'b0;
            r_ex_imm     <= '0;
            r_ex_rd      <= '0;
        end else if (w_issue) begin
            r_ex_valid   <= 1'b1;
            r_ex_in1     <= w_op1;
            r_ex_in2     <= w_op2;
            r_ex_opcode  <= w_op;
            r_ex_sr_cont <= w_sr_cont;
            r_ex_sr_bit  <= w_sr_bit;
            r_ex_s       <= w_s;
            r_ex_imm     <= w_imm;
            r_ex_rd      <= w_rd;
        end else if (bus.ex_ready) begin
            r_ex_valid <= 1'b0;
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.ex_valid   = r_ex_valid;
    assign bus.ex_in1     = r_ex_in1;
    assign bus.ex_in2     = r_ex_in2;
    assign bus.ex_opcode  = r_ex_opcode;
    assign bus.ex_sr_cont = r_ex_sr_cont;
    assign bus.ex_sr_bit  = r_ex_sr_bit;
    assign bus.ex_s       = r_ex_s;
    assign bus.ex_imm     = r_ex_imm;
    assign bus.ex_rd      = r_ex_rd;
    assign bus.flags      = r_flags;
    assign bus.squash_cnt = r_squash;
endmodule

// File: doc/decode_issue_stage.md
DECODE_ISSUE_STAGE -- requirements
Module: decode_issue_stage

Interface
REQ-001 Parameter FLAGS_RST, default 4'b0000, reset value of the {N,Z,C,V} flags register.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 in_valid  in  1  instruction word present; in_ready  out  1  stage accepts it this cycle.
REQ-006 instr  in  32  [31:28] Cond, [27:24] Opcode, [23] S, [22:19] Rd, [18:15] Rn, [14:11] Rm, [10:8] SR_Cont, [7:3] SR_Bit, [15:0] Immediate.
REQ-007 ex_valid  out  1  issued bundle valid; ex_ready  in  1  ALU stage consumes bundle.
REQ-008 ex_in1, ex_in2  out  32 each  operands read from Rn and Rm.
REQ-009 ex_opcode 4, ex_sr_cont 3, ex_sr_bit 5, ex_s 1, ex_imm 16, ex_rd 4  out  decoded fields for the ALU.
REQ-010 wb_en  in  1, wb_addr  in  4, wb_data  in  32  register write-back from ALU Out.
REQ-011 wb_flags_en  in  1, wb_flags  in  4  flags write-back ({N,Z,C,V}).
REQ-012 flags  out  4  current architectural flags; squash_cnt  out  16  count of condition-failed instructions.

Function
REQ-013 Internal register file: 16 x 32 bits, two combinational read ports (Rn, Rm), one write port from wb_*.
REQ-014 Write-back to the register being read in the same cycle SHALL bypass: operand equals wb_data.
REQ-015 Flags register SHALL load wb_flags on the clock edge where wb_flags_en=1.
REQ-016 Scoreboard: one pending bit per register; set on issue of opcode 4'b0000-4'b0111 for ex_rd; cleared when wb_en=1 for that address; same-cycle set and clear of one register -> set wins.
REQ-017 Flags-pending counter (2 bits): increments on issue with S=1 or opcode 4'b1000 (CMP); decrements on wb_flags_en; simultaneous -> unchanged; saturates at 3 and stalls further flag-setting issue when 3.
REQ-018 Opcodes 4'b0110 (MOVI) source no register; 4'b0111 (MOV) sources Rn only; others source Rn and Rm.
REQ-019 RAW stall: in_ready=0 when any sourced register is pending, unless wb_en clears it this cycle.
REQ-020 Condition stall: Cond!=4'b1110 with flags-pending counter nonzero -> in_ready=0.
REQ-021 Output stage: single register; in_ready = !stall && (!ex_valid || ex_ready).
REQ-022 Accepted instruction passing Cond loads the output register with 1-cycle latency; ex_valid=1 next cycle.
REQ-023 ex_valid SHALL stay 1 and all ex_* outputs stable until ex_ready=1.
REQ-024 Cond codes: 0000 EQ Z; 0001 NE !Z; 0010 CS C; 0011 CC !C; 0100 MI N; 0101 PL !N; 0110 VS V; 0111 VC !V; 1000 HI C&!Z; 1001 LS !C|Z; 1010 GE N==V; 1011 LT N!=V; 1100 GT !Z&(N==V); 1101 LE Z|(N!=V); 1110 AL; 1111 NV never.
REQ-025 Condition-failed instruction: accepted (handshake completes), no issue, no scoreboard or flags-pending update, squash_cnt += 1 wrapping 16'hFFFF->0.
REQ-026 Opcodes 4'b1001-4'b1111 (unimplemented) SHALL be accepted and dropped like a failed condition, without counting.
REQ-027 Fire on output and new accept in the same cycle SHALL replace the register with no bubble.

Reset
REQ-028 On rst: ex_valid=0, all ex_* fields 0, flags=FLAGS_RST, squash_cnt=0, scoreboard and flags-pending cleared, all 16 registers 0.
REQ-029 rst asserted mid-handshake discards the held bundle; in_ready is 0 while rst=1 and 1 on the first cycle after release.

Verification
REQ-030 After reset, wb R1=5, R2=7; issue ADD Cond=1110 Rd=3 Rn=1 Rm=2 -> next cycle ex_valid=1, ex_in1=5, ex_in2=7, ex_rd=3.
REQ-031 Issue ADD Rd=3, then SUB Rn=3 with no wb -> in_ready=0; wb_en R3=12 -> SUB accepted that cycle with ex_in1=12 next cycle.
REQ-032 flags=0100 (Z=1); issue Cond=0001 NE -> ex_valid stays 0, squash_cnt=1; Cond=0000 EQ -> issued.
REQ-033 Hold ex_ready=0 for 3 cycles with in_valid=1 -> ex_* stable, in_ready=0; ex_ready=1 -> back-to-back issue, no bubble.
REQ-034 Issue CMP, then Cond=1010 instruction -> stalled until wb_flags_en=1 with 1000, then squashed (GE false).
REQ-035 Assert rst while ex_valid=1 and ex_ready=0 -> ex_valid=0 immediately, flags=FLAGS_RST, R1 reads 0.
